// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq: request side (A, B, opcode, Cin)
// and response side (Out, zero, err), each with its own valid/ready pair.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         opcode;
  logic               Cin;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] Out;
  logic               zero;
  logic               err;

  modport master (output in_valid, A, B, opcode, Cin, out_ready,
                  input  in_ready, out_valid, Out, zero, err);
  modport slave  (input  in_valid, A, B, opcode, Cin, out_ready,
                  output in_ready, out_valid, Out, zero, err);
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus an iterative restoring divider.
// ALU_SEQ_ITER_MUL_EN: when defined, opcode 010 runs a WIDTH-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int W2 = 2*WIDTH;

`ifdef ALU_SEQ_ITER_MUL_EN
  typedef enum logic [1:0] {IDLE, DIV, DONE, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] b_r, quo, rem;
  logic [2:0]       op_r;
  logic [W2-1:0]    out_r;
  logic             zero_r, err_r, out_valid_r, in_ready_r;

  assign bus.Out       = out_r;
  assign bus.zero      = zero_r;
  assign bus.err       = err_r;
  assign bus.out_valid = out_valid_r;
  assign bus.in_ready  = in_ready_r;

  // Result of a single-cycle op, evaluated on the live inputs at the accept edge
  logic [WIDTH:0]  add_s, sub_s;
  logic [W2-1:0]   res_now;
  logic            div_op, b_zero, iter;
  always_comb begin
    add_s   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
    sub_s   = {1'b0, bus.A} - {1'b0, bus.B};
    div_op  = (bus.opcode == 3'b011) || (bus.opcode == 3'b100);
    b_zero  = (bus.B == '0);
    iter    = div_op && !b_zero;
`ifdef ALU_SEQ_ITER_MUL_EN
    if (bus.opcode == 3'b010) iter = 1'b1;
`endif
    res_now = '0;
    case (bus.opcode)
      3'b000: res_now = W2'(add_s);
      3'b001: res_now = W2'(sub_s);
`ifdef ALU_SEQ_ITER_MUL_EN
      3'b010: res_now = '0;
`else
      3'b010: res_now = W2'(bus.A) * W2'(bus.B);
`endif
      3'b011: res_now = W2'({WIDTH{1'b1}});
      3'b100: res_now = W2'(bus.A);
      3'b101: res_now = W2'(bus.A & bus.B);
      3'b110: res_now = W2'(bus.A | bus.B);
      default: res_now = W2'(bus.A ^ bus.B);
    endcase
  end

  // One restoring-division step: quo shifts the dividend out MSB-first, quotient bits in LSB-first
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [W2-1:0]    div_res;
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    ge      = (trial >= {1'b0, b_r});
    rem_n   = ge ? WIDTH'(trial - {1'b0, b_r}) : trial[WIDTH-1:0];
    quo_n   = {quo[WIDTH-2:0], ge};
    div_res = (op_r == 3'b011) ? W2'(quo_n) : W2'(rem_n);
  end

`ifdef ALU_SEQ_ITER_MUL_EN
  // Shift-add step: {rem,quo} is the running product, quo LSB is the current multiplier bit
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] rem_m, quo_m;
  always_comb begin
    msum  = {1'b0, rem} + (quo[0] ? {1'b0, b_r} : '0);
    rem_m = msum[WIDTH:1];
    quo_m = {msum[0], quo[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      b_r         <= '0;
      quo         <= '0;
      rem         <= '0;
      op_r        <= '0;
      out_r       <= '0;
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_r       <= bus.opcode;
          b_r        <= bus.B;
          quo        <= bus.A;
          rem        <= '0;
          zero_r     <= 1'b0;
          err_r      <= 1'b0;
          in_ready_r <= 1'b0;
          if (iter) begin
            cnt   <= CNT_W'(WIDTH);
`ifdef ALU_SEQ_ITER_MUL_EN
            state <= (bus.opcode == 3'b010) ? MUL : DIV;
`else
            state <= DIV;
`endif
          end else begin
            out_r       <= res_now;
            zero_r      <= (res_now == '0);
            err_r       <= div_op && b_zero;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DIV: begin
          quo <= quo_n;
          rem <= rem_n;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            out_r       <= div_res;
            zero_r      <= (div_res == '0);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
`ifdef ALU_SEQ_ITER_MUL_EN
        MUL: begin
          quo <= quo_m;
          rem <= rem_m;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            out_r       <= {rem_m, quo_m};
            zero_r      <= ({rem_m, quo_m} == '0);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
`endif
        DONE: if (bus.out_ready) begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
